// File: rtl/uart_rx.sv
// UART receiver: 2-flop rxd synchronizer, clk16x-derived tick, start/data/stop FSM
// and a single-byte holding register with ack, overrun and frame-error reporting.
module uart_rx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk_input,
   input  logic                 rst,
   input  logic                 clk16x,
   input  logic                 rxd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 rxd_meta_q, rxd_sync_q;
   logic                 c16_q, c16_prev_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q, frame_err_q, overrun_q, busy_q;
   logic                 tick;
   logic                 byte_done;

   // Synchronize rxd and sample clk16x as a plain level
   always_ff @(posedge clk_input or posedge rst) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         c16_q      <= 1'b0;
         c16_prev_q <= 1'b0;
      end else begin
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
         c16_q      <= clk16x;
         c16_prev_q <= c16_q;
      end
   end

   assign tick      = c16_q & ~c16_prev_q;
   assign byte_done = tick && (state_q == STOP) && (cnt_q == CNT_LAST) && rxd_sync_q;

   // Frame FSM; busy tracks every non-IDLE transition
   always_ff @(posedge clk_input or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (tick) begin
            case (state_q)
               IDLE: begin
                  if (!rxd_sync_q) begin
                     state_q <= START;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               START: begin
                  if (cnt_q == CNT_MID) begin
                     cnt_q <= '0;
                     if (!rxd_sync_q) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               DATA: begin
                  if (cnt_q == CNT_LAST) begin
                     shift_q <= {rxd_sync_q, shift_q[DATA_BITS-1:1]};
                     cnt_q   <= '0;
                     if (idx_q == IDX_LAST) begin
                        state_q <= STOP;
                        idx_q   <= '0;
                     end else begin
                        idx_q <= idx_q + IDX_W'(1);
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               STOP: begin
                  if (cnt_q == CNT_LAST) begin
                     state_q     <= IDLE;
                     cnt_q       <= '0;
                     busy_q      <= 1'b0;
                     frame_err_q <= ~rxd_sync_q;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Holding register: a completion only lands when the slot is free or being acked
   always_ff @(posedge clk_input or posedge rst) begin
      if (rst) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (byte_done && (!rx_valid_q || rx_ack)) begin
         rx_data_q  <= shift_q;
         rx_valid_q <= 1'b1;
         overrun_q  <= 1'b0;
      end else if (byte_done) begin
         overrun_q <= 1'b1;
      end else if (rx_ack && rx_valid_q) begin
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (LSB first, no parity, 1 stop bit).
REQ-002 Parameter: OVERSAMPLE, default 16, number of clk16x rising edges per bit period.
REQ-003 Port: clk_input  in  1  system clock; all logic is clocked on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: clk16x  in  1  16x-baud square wave from the clock divider; used only as a sampled level, never as a clock.
REQ-006 Port: rxd  in  1  asynchronous serial line; idle high.
REQ-007 Port: rx_ack  in  1  consumer acknowledge; one clk_input cycle high consumes the held byte.
REQ-008 Port: rx_data  out  DATA_BITS  last accepted byte.
REQ-009 Port: rx_valid  out  1  level; high while rx_data holds an unacknowledged byte.
REQ-010 Port: frame_err  out  1  one-cycle pulse when a stop bit samples low.
REQ-011 Port: overrun  out  1  sticky; a byte completed while rx_valid was high and not acked.
REQ-012 Port: busy  out  1  high in every state except IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle latency).
REQ-014 clk16x SHALL be registered, and tick SHALL be high for exactly one clk_input cycle per 0->1 transition of registered clk16x.
REQ-015 All state/counter updates below SHALL occur only on tick cycles, except the rx_ack, rx_valid and overrun handling.
REQ-016 FSM states: IDLE, START, DATA, STOP; a 4-bit sample counter cnt and a bit index idx (0..DATA_BITS-1).
REQ-017 IDLE: on tick with rxd=0 -> START, cnt=0; otherwise remain.
REQ-018 START: cnt increments each tick; at cnt=7 (mid-bit): rxd=0 -> DATA, cnt=0, idx=0; rxd=1 -> IDLE (false start, no outputs change).
REQ-019 DATA: cnt increments each tick; at cnt=OVERSAMPLE-1, rxd is shifted into the MSB of the shift register (LSB-first reception), cnt=0, idx increments; after bit DATA_BITS-1 -> STOP.
REQ-020 STOP: at cnt=OVERSAMPLE-1: rxd=1 -> byte completes, IDLE; rxd=0 -> frame_err pulses for 1 cycle, byte discarded, IDLE.
REQ-021 Byte completion with rx_valid=0, or with rx_ack=1 in the same cycle: rx_data<=shift register, rx_valid=1 from the next cycle.
REQ-022 Byte completion with rx_valid=1 and rx_ack=0: rx_data SHALL be unchanged, the new byte is dropped, and overrun is set.
REQ-023 rx_ack=1 without a simultaneous completion: rx_valid=0 and overrun=0 on the next cycle; rx_ack while rx_valid=0 has no effect.
REQ-024 Each frame receives no more than one completion and produces no more than one frame_err; no byte is ever partially written to rx_data.
REQ-025 A low rxd in STOP that persists SHALL start a new frame only after the FSM returns to IDLE (a break is received as repeated frame errors).

Reset
REQ-026 On rst=1, immediately and independent of the clock: state=IDLE, cnt=0, idx=0, shift register=0, synchronizer flops=1, registered clk16x=0.
REQ-027 Output values during and immediately after reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Asserting rst mid-frame SHALL abort the frame with no rx_valid and no frame_err; reception resumes at the next falling start edge after release.

Verification
REQ-029 Frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) at 16 ticks/bit -> rx_data=0x55, rx_valid=1 until rx_ack, then 0.
REQ-030 rxd low for 4 ticks only -> FSM returns to IDLE at cnt=7; rx_valid, frame_err and busy all 0 afterward.
REQ-031 Frame 0xA3 with stop bit 0 -> one frame_err pulse, rx_valid stays 0, and rx_data is unchanged.
REQ-032 Frames 0x12 then 0x34 with no ack -> rx_data=0x12 and overrun=1; one rx_ack -> rx_valid=0, overrun=0.
REQ-033 rx_ack on the same cycle as completion of 0x34 (previous byte 0x12) -> rx_data=0x34, rx_valid=1, overrun=0.
REQ-034 rst pulse during the DATA state of 0xFF, followed by a clean frame 0x0F -> only 0x0F is delivered, with no frame_err.
